int_ram_loader: RTL and testbench
=================================

# int_ram_loader

Ping-pong controller for the two intrinsic-message RAM banks. It accepts a stream of channel LLRs over a valid/ready handshake and writes each frame into one bank while the decoder reads the previously completed frame from the other bank. It sits between the channel front-end and the intrinsic RAM pair: it drives the RAM address, data, write-enable, chip-select and RAM-select lines, and returns read data to the decoder.

## Interface
- DATA_WIDTH, 5, LLR width in bits.
- ADDR_WIDTH, 8, RAM address width in bits.
- FRAME_LEN, 1 << ADDR_WIDTH, LLRs per frame; must be ≤ 2^ADDR_WIDTH.

- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  LLR stream word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  DATA_WIDTH  channel LLR.
- frame_ready  out  1  the read bank holds a complete frame.
- dec_done  in  1  single-cycle pulse: decoder releases the read bank.
- dec_rd_en  in  1  decoder read request.
- dec_addr  in  ADDR_WIDTH  decoder read address.
- dec_data  out  DATA_WIDTH  read data, valid 1 cycle after the request.
- ram_address  out  ADDR_WIDTH ×[0:1]  per-bank address.
- ram_data_in  out  DATA_WIDTH ×[0:1]  per-bank write data.
- ram_data_out  in  DATA_WIDTH ×[0:1]  per-bank synchronous read data.
- ram_we  out  1 ×[0:1]  per-bank write enable.
- ram_cs  out  1 ×[0:1]  per-bank chip select.
- rs  out  1  RAM select; equals the current read bank.

## Operation
- State registers:
  - wr_bank, rd_bank (1 bit each).
  - wr_cnt (ADDR_WIDTH bits).
  - bank_st[0:1], each EMPTY or FULL.
  - rd_sel_q: the bank used by the last read, held for the data mux.
- Write path:
  - s_ready = (bank_st[wr_bank] == EMPTY), decoded from registers only.
  - A word is accepted when s_valid && s_ready. On acceptance, drive bank wr_bank with ram_cs=1, ram_we=1, ram_address=wr_cnt, ram_data_in=s_data, then increment wr_cnt.
  - When wr_cnt == FRAME_LEN-1 is accepted:
    - bank_st[wr_bank] ← FULL.
    - wr_bank toggles.
    - wr_cnt ← 0.
  - There is no wrap within a bank beyond FRAME_LEN-1.
- Read path:
  - frame_ready = (bank_st[rd_bank] == FULL).
  - dec_rd_en is honoured only when frame_ready. It drives bank rd_bank with ram_cs=1, ram_we=0, ram_address=dec_addr.
  - dec_rd_en while !frame_ready is ignored; dec_data holds its previous value.
  - dec_data = ram_data_out[rd_sel_q]. rd_sel_q is captured on every honoured read.
- Release:
  - dec_done with frame_ready sets bank_st[rd_bank] ← EMPTY and toggles rd_bank.
  - dec_done without frame_ready is ignored.
- Bank access: a bank is never written and read in the same cycle, because the writer only targets EMPTY banks and the reader only FULL ones. Per-bank strobes are muxed by bank ownership.
- Simultaneous events:
  - Frame completion and dec_done on opposite banks in the same cycle: both updates take effect.
  - dec_done freeing the current wr_bank raises s_ready on the next cycle, never combinationally.
  - dec_rd_en in the same cycle as dec_done: the read is performed from the releasing bank, and rd_sel_q keeps the data valid.
- Reset, including mid-frame:
  - All state clears: wr_bank = rd_bank = 0, wr_cnt = 0, both banks EMPTY.
  - A partially loaded frame is discarded.
  - Output reset values: s_ready = 1, frame_ready = 0, rs = 0, dec_data = 0, and all ram_we, ram_cs, ram_address, ram_data_in = 0.

## Timing
- Write: the RAM write occurs on the same edge that accepts the word. Zero bubble; one word per cycle sustained.
- Last word of a frame at edge N: frame_ready = 1 after edge N, provided that bank becomes rd_bank.
- Read latency: dec_data is valid exactly one cycle after dec_rd_en.
- Release: dec_done at edge N gives frame_ready and rs reflecting the other bank after edge N.
- Steady-state throughput: one frame loads while one frame is decoded.

## Structure
- Shared package int_ram_pkg:
  - bank_state_t enum {EMPTY, FULL}.
  - NUM_BANKS = 2.
  - Default DATA_WIDTH and ADDR_WIDTH constants.
- Sub-module int_bank_arbiter: combinational mux of write-side and read-side strobes onto the per-bank RAM ports, keyed by wr_bank and rd_bank.
- The top level holds the counters, bank-state registers and the dec_data mux.

## Test plan
- Reset, then stream 256 LLRs valued 0..255 mod 32 continuously, FRAME_LEN=256:
  - bank 0 gets ram_we at addresses 0..255;
  - frame_ready rises the cycle after word 255;
  - s_ready stays 1, now targeting bank 1.
- Load two frames with no dec_done: s_ready drops after word 511, and s_valid is back-pressured with no writes.
- With frame 0 ready, read addresses 0, 5, 255: dec_data returns 0, 5, 31 one cycle after each request, with rs = 0.
- With frame_ready=1, pulse dec_done in the same cycle as the last write of frame 1: the release and the completion both take effect, and the next cycle shows rs = 1, frame_ready = 1 and s_ready = 1.
- Assert rst asynchronously mid-frame at word 100: outputs reach their reset values immediately, and the next frame writes from address 0 of bank 0.
- Issue dec_rd_en and dec_done while frame_ready = 0: no ram_cs, and state is unchanged.

Source files
------------

// File: rtl/int_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : int_ram_pkg
// Purpose  : Shared types and constants for the intrinsic RAM ping-pong
//            loader: bank occupancy state, bank count, default widths.
// Revision : 1.0 - initial release
// ============================================================================
package int_ram_pkg;

    // Occupancy of one intrinsic RAM bank.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_t;

    localparam int NUM_BANKS          = 2;
    localparam int DEFAULT_DATA_WIDTH = 5;
    localparam int DEFAULT_ADDR_WIDTH = 8;

endpackage : int_ram_pkg
`default_nettype wire

// File: rtl/int_ram_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : int_ram_loader_if
// Purpose  : Bundle of the LLR stream handshake, decoder read/release port
//            and the per-bank intrinsic RAM strobes.
// Modports : slave  - the loader (drives s_ready, frame_ready, dec_data,
//                     RAM strobes and rs)
//            master - the environment (front-end, decoder, RAM pair)
// Revision : 1.0 - initial release
// ============================================================================
interface int_ram_loader_if
    import int_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

    // LLR stream
    logic                                   s_valid;
    logic                                   s_ready;
    logic [DATA_WIDTH-1:0]                  s_data;

    // Decoder side
    logic                                   frame_ready;
    logic                                   dec_done;
    logic                                   dec_rd_en;
    logic [ADDR_WIDTH-1:0]                  dec_addr;
    logic [DATA_WIDTH-1:0]                  dec_data;

    // Intrinsic RAM pair
    logic [0:NUM_BANKS-1][ADDR_WIDTH-1:0]   ram_address;
    logic [0:NUM_BANKS-1][DATA_WIDTH-1:0]   ram_data_in;
    logic [0:NUM_BANKS-1][DATA_WIDTH-1:0]   ram_data_out;
    logic [0:NUM_BANKS-1]                   ram_we;
    logic [0:NUM_BANKS-1]                   ram_cs;
    logic                                   rs;

    modport slave (
        input  s_valid, s_data, dec_done, dec_rd_en, dec_addr, ram_data_out,
        output s_ready, frame_ready, dec_data, ram_address, ram_data_in,
               ram_we, ram_cs, rs
    );

    modport master (
        output s_valid, s_data, dec_done, dec_rd_en, dec_addr, ram_data_out,
        input  s_ready, frame_ready, dec_data, ram_address, ram_data_in,
               ram_we, ram_cs, rs
    );

endinterface : int_ram_loader_if
`default_nettype wire

// File: rtl/int_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : int_bank_arbiter
// Purpose  : Combinational steering of the write-side and read-side strobes
//            onto the per-bank RAM ports, keyed by the bank each side owns.
// Ports    : i_wr_*       - accepted write (bank, address, data)
//            i_rd_*       - honoured read (bank, address)
//            o_ram_*      - per-bank address / data / we / cs
// Revision : 1.0 - initial release
// ============================================================================
module int_bank_arbiter
    import int_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  wire logic                                  i_wr_fire,
    input  wire logic                                  i_wr_bank,
    input  wire logic [ADDR_WIDTH-1:0]                 i_wr_addr,
    input  wire logic [DATA_WIDTH-1:0]                 i_wr_data,
    input  wire logic                                  i_rd_fire,
    input  wire logic                                  i_rd_bank,
    input  wire logic [ADDR_WIDTH-1:0]                 i_rd_addr,
    output logic      [0:NUM_BANKS-1][ADDR_WIDTH-1:0]  o_ram_address,
    output logic      [0:NUM_BANKS-1][DATA_WIDTH-1:0]  o_ram_data_in,
    output logic      [0:NUM_BANKS-1]                  o_ram_we,
    output logic      [0:NUM_BANKS-1]                  o_ram_cs
);

    // The writer only targets EMPTY banks and the reader only FULL ones, so
    // at most one side selects a given bank; idle banks see all-zero strobes.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic w_wr_sel;
        logic w_rd_sel;

        assign w_wr_sel = i_wr_fire && (i_wr_bank == 1'(b));
        assign w_rd_sel = i_rd_fire && (i_rd_bank == 1'(b));

        assign o_ram_cs[b]      = w_wr_sel || w_rd_sel;
        assign o_ram_we[b]      = w_wr_sel;
        assign o_ram_address[b] = w_wr_sel ? i_wr_addr :
                                  w_rd_sel ? i_rd_addr : '0;
        assign o_ram_data_in[b] = w_wr_sel ? i_wr_data : '0;
    end

endmodule : int_bank_arbiter
`default_nettype wire

// File: rtl/int_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : int_ram_loader
// Purpose  : Ping-pong controller for the two intrinsic-message RAM banks.
//            Streams LLR frames into the write bank while the decoder reads
//            the previously completed frame from the read bank.
// Ports    : clk, rst     - clock, asynchronous active-high reset
//            bus (slave)  - stream handshake, decoder port, RAM strobes, rs
// Revision : 1.0 - initial release
// ============================================================================
module int_ram_loader
    import int_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    // Must not exceed 2**ADDR_WIDTH.
    parameter int FRAME_LEN  = 1 << ADDR_WIDTH
) (
    input  wire logic        clk,
    input  wire logic        rst,
    int_ram_loader_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

    logic                   wr_bank_q, wr_bank_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH-1:0]  wr_cnt_q,  wr_cnt_d;
    bank_state_t            bank_st_q [NUM_BANKS];
    bank_state_t            bank_st_d [NUM_BANKS];
    logic                   rd_sel_q,  rd_sel_d;
    // Set by the first honoured read; keeps dec_data at zero until the
    // RAM output register holds something this loader asked for.
    logic                   rd_seen_q, rd_seen_d;

    logic w_s_ready;
    logic w_frame_ready;
    logic w_wr_fire;
    logic w_wr_last;
    logic w_rd_fire;
    logic w_release;

    // Handshake flags come from registers only, so a release never raises
    // s_ready in the same cycle. Strobes are masked while rst is asserted so
    // the RAM ports read zero immediately on an asynchronous reset.
    assign w_s_ready     = (bank_st_q[wr_bank_q] == EMPTY);
    assign w_frame_ready = (bank_st_q[rd_bank_q] == FULL);
    assign w_wr_fire     = bus.s_valid && w_s_ready && !rst;
    assign w_wr_last     = w_wr_fire && (wr_cnt_q == C_LAST_ADDR);
    assign w_rd_fire     = bus.dec_rd_en && w_frame_ready && !rst;
    assign w_release     = bus.dec_done && w_frame_ready;

    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        bank_st_d = bank_st_q;
        rd_sel_d  = rd_sel_q;
        rd_seen_d = rd_seen_q;

        if (w_wr_fire) begin
            if (w_wr_last) begin
                bank_st_d[wr_bank_q] = FULL;
                wr_bank_d            = ~wr_bank_q;
                wr_cnt_d             = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end

        // Completion and release always touch different banks (the writer's
        // bank is EMPTY, the reader's is FULL), so both may apply at once.
        if (w_release) begin
            bank_st_d[rd_bank_q] = EMPTY;
            rd_bank_d            = ~rd_bank_q;
        end

        // rd_sel keeps the data mux on the bank actually read, even when the
        // same cycle's release moves rd_bank away.
        if (w_rd_fire) begin
            rd_sel_d  = rd_bank_q;
            rd_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_st_q[b] <= EMPTY;
            end
            rd_sel_q  <= 1'b0;
            rd_seen_q <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            bank_st_q <= bank_st_d;
            rd_sel_q  <= rd_sel_d;
            rd_seen_q <= rd_seen_d;
        end
    end

    int_bank_arbiter #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_arbiter (
        .i_wr_fire     (w_wr_fire),
        .i_wr_bank     (wr_bank_q),
        .i_wr_addr     (wr_cnt_q),
        .i_wr_data     (bus.s_data),
        .i_rd_fire     (w_rd_fire),
        .i_rd_bank     (rd_bank_q),
        .i_rd_addr     (bus.dec_addr),
        .o_ram_address (bus.ram_address),
        .o_ram_data_in (bus.ram_data_in),
        .o_ram_we      (bus.ram_we),
        .o_ram_cs      (bus.ram_cs)
    );

    assign bus.s_ready     = w_s_ready;
    assign bus.frame_ready = w_frame_ready;
    assign bus.rs          = rd_bank_q;
    assign bus.dec_data    = rd_seen_q ? bus.ram_data_out[rd_sel_q] : '0;

endmodule : int_ram_loader
`default_nettype wire

// File: tb/tb_int_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_ram_loader
// Purpose  : Self-checking bench for int_ram_loader. Stimulus pushes
//            expected status, writes and reads into queues derived from a
//            frame-level model (frames loaded / frames released); a negedge
//            monitor pops and compares against what the DUT presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_ram_loader;

    localparam int DW = 5;
    localparam int AW = 8;
    localparam int FL = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int_ram_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    int_ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural synchronous RAM pair: output register updates on reads only.
    logic [DW-1:0] ram_mem  [2][FL];
    logic [0:1][DW-1:0] ram_dout = '1;
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (bus.ram_cs[b] && bus.ram_we[b]) ram_mem[b][bus.ram_address[b]] <= bus.ram_data_in[b];
            if (bus.ram_cs[b] && !bus.ram_we[b]) ram_dout[b] <= ram_mem[b][bus.ram_address[b]];
        end
    end
    assign bus.ram_data_out = ram_dout;

    // Frame-level reference model.
    int            m_loaded, m_released, m_cur;
    logic [DW-1:0] m_mem [2][FL];

    function automatic logic m_can_acc();  return (m_loaded - m_released) < 2; endfunction
    function automatic logic m_fr();       return m_loaded > m_released;       endfunction
    function automatic logic m_wb();       return 1'(m_loaded % 2);            endfunction
    function automatic logic m_rb();       return 1'(m_released % 2);          endfunction

    // Scoreboard queues.
    logic [2:0]       st_q [$];   // {s_ready, frame_ready, rs}
    logic [AW+DW:0]   wr_q [$];   // {bank, addr, data}
    logic [AW+DW:0]   rd_q [$];   // {bank, addr, expected data}
    logic [DW-1:0]    exp_dec = '0;
    logic             rd_pend = 1'b0;
    logic [DW-1:0]    pend_data = '0;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Negedge monitor.
    always @(negedge clk) begin
        if (!rst) begin
            logic [2:0]     st;
            logic [AW+DW:0] e;
            if (rd_pend) begin
                exp_dec = pend_data;
                rd_pend = 1'b0;
            end
            check("dec_data", int'(bus.dec_data), int'(exp_dec));
            if (st_q.size() > 0) begin
                st = st_q.pop_front();
                check("s_ready",     int'(bus.s_ready),     int'(st[2]));
                check("frame_ready", int'(bus.frame_ready), int'(st[1]));
                check("rs",          int'(bus.rs),          int'(st[0]));
            end
            for (int b = 0; b < 2; b++) begin
                if (bus.ram_we[b] && !bus.ram_cs[b]) check("we_without_cs", 1, 0);
                if (bus.ram_cs[b] && bus.ram_we[b]) begin
                    if (wr_q.size() == 0) check("unexpected_write", 1, 0);
                    else begin
                        e = wr_q.pop_front();
                        check("wr_bank", b, int'(e[AW+DW]));
                        check("wr_addr", int'(bus.ram_address[b]), int'(e[AW+DW-1:DW]));
                        check("wr_data", int'(bus.ram_data_in[b]), int'(e[DW-1:0]));
                    end
                end else if (bus.ram_cs[b]) begin
                    if (rd_q.size() == 0) check("unexpected_read", 1, 0);
                    else begin
                        e = rd_q.pop_front();
                        check("rd_bank", b, int'(e[AW+DW]));
                        check("rd_addr", int'(bus.ram_address[b]), int'(e[AW+DW-1:DW]));
                        pend_data = e[DW-1:0];
                        rd_pend   = 1'b1;
                    end
                end
            end
        end
    end

    // One cycle of stimulus; entered and left at posedge+1.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic rd,
                         input logic [AW-1:0] a, input logic dn);
        bus.s_valid   = v;
        bus.s_data    = d;
        bus.dec_rd_en = rd;
        bus.dec_addr  = a;
        bus.dec_done  = dn;
        st_q.push_back({m_can_acc(), m_fr(), m_rb()});
        if (rd && m_fr()) rd_q.push_back({m_rb(), a, m_mem[m_rb()][a]});
        if (v && m_can_acc()) begin
            wr_q.push_back({m_wb(), AW'(m_cur), d});
            m_mem[m_wb()][m_cur] = d;
            m_cur++;
            if (m_cur == FL) begin
                m_cur = 0;
                m_loaded++;
            end
        end
        if (dn && m_fr()) m_released++;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_loaded = 0; m_released = 0; m_cur = 0;
        st_q.delete(); wr_q.delete(); rd_q.delete();
        exp_dec = '0; rd_pend = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_s_ready",     int'(bus.s_ready),     1);
        check("rst_frame_ready", int'(bus.frame_ready), 0);
        check("rst_rs",          int'(bus.rs),          0);
        check("rst_dec_data",    int'(bus.dec_data),    0);
        check("rst_ram_we",      int'(bus.ram_we),      0);
        check("rst_ram_cs",      int'(bus.ram_cs),      0);
        check("rst_ram_address", int'(bus.ram_address), 0);
        check("rst_ram_data_in", int'(bus.ram_data_in), 0);
    endtask

    function automatic logic [AW-1:0] pick_addr(input int i);
        case (i)
            0:       return 8'd0;
            1:       return 8'd5;
            default: return 8'd255;
        endcase
    endfunction

    initial begin
        bus.s_valid = 0; bus.s_data = 0; bus.dec_rd_en = 0;
        bus.dec_addr = 0; bus.dec_done = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // Frame 0: values i mod 32, continuous.
        for (int i = 0; i < FL; i++) drive(1'b1, DW'(i % 32), 1'b0, '0, 1'b0);

        // Frame 1 while reading 0, 5, 255 of frame 0; release on last word.
        for (int i = 0; i < FL; i++)
            drive(1'b1, DW'($urandom), (i < 3), pick_addr(i), (i == FL - 1));
        drive(1'b0, '0, 1'b0, '0, 1'b0);

        // Frame 2 into bank 0 with bank 1 still full, then back-pressure.
        for (int i = 0; i < FL; i++)
            drive(1'b1, DW'($urandom), ($urandom_range(0, 7) == 0), AW'($urandom), 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, DW'($urandom), 1'b0, '0, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++)
            drive(($urandom_range(0, 3) != 0), DW'($urandom), $urandom_range(0, 1) == 1,
                  AW'($urandom), ($urandom_range(0, 199) == 0));

        // Asynchronous reset in the middle of a frame, at word 100.
        rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) drive(1'b1, DW'($urandom), 1'b0, '0, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = DW'($urandom);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // Read and release with no frame ready: ignored.
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, AW'($urandom), 1'b1);

        // Fresh frame from address 0 of bank 0, then read it back.
        for (int i = 0; i < FL; i++) drive(1'b1, DW'($urandom), 1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, AW'($urandom), 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (3) drive(1'b0, '0, 1'b0, '0, 1'b0);

        check("pending_writes", wr_q.size(), 0);
        check("pending_reads",  rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_int_ram_loader
`default_nettype wire
